nfu2_window_seq: RTL and testbench

NFU2_WINDOW_SEQ -- requirements
Module: nfu2_window_seq

---
 rtl/nfu2_pkg.sv | 19 +
 rtl/nfu2_group_counter.sv | 30 +++
 rtl/nfu2_window_seq.sv | 138 +++++++++++++
 tb/tb_nfu2_window_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfu2_pkg.sv
// Shared definitions for the NFU-2 window sequencer: default geometry,
// operation encodings and the controller state type.
package nfu2_pkg;

    localparam int unsigned NFU2_N     = 16;
    localparam int unsigned NFU2_TN    = 16;
    localparam int unsigned NFU2_CNT_W = 8;

    localparam logic OP_SUM = 1'b0;
    localparam logic OP_MAX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_OUT
    } seq_state_t;

endpackage

// File: rtl/nfu2_group_counter.sv
// Counts groups accepted in the current window and flags the group that
// completes it (the one whose acceptance brings the count to num_groups).
module nfu2_group_counter
    import nfu2_pkg::*;
#(
    parameter int CNT_W = NFU2_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] num_groups,
    output logic             last
);

    logic [CNT_W-1:0] count_q;

    // Group count: cleared on reset or window start, bumped on each accept.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Compare one bit wider so a full-scale num_groups cannot wrap.
    assign last = (({1'b0, count_q} + (CNT_W+1)'(1)) == {1'b0, num_groups});

endmodule

// File: rtl/nfu2_window_seq.sv
// Window sequencer for the NFU-2 sum/max tree cluster. Feeds groups into the
// cluster, chains the partial result back as the psum operand, and presents
// the final window result on a valid/ready port.
// Optional feature: define NFU2_SEQ_INIT_PSUM_EN to add i_init_psum, which is
// latched at start and used as the psum operand of the first group.
module nfu2_window_seq
    import nfu2_pkg::*;
#(
    parameter int N     = NFU2_N,
    parameter int Tn    = NFU2_TN,
    parameter int CNT_W = NFU2_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_op,
    input  logic [CNT_W-1:0]  i_num_groups,
`ifdef NFU2_SEQ_INIT_PSUM_EN
    input  logic [Tn*N-1:0]   i_init_psum,
`endif
    output logic              o_busy,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_tree_op,
    output logic [Tn*N-1:0]   o_tree_psum,
    input  logic [Tn*N-1:0]   i_tree_res,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [Tn*N-1:0]   o_out_data
);

    localparam int W = Tn * N;

    seq_state_t       state_q;
    logic             op_q;
    logic [CNT_W-1:0] num_q;
    logic             pipe_v_q;
    logic             use_acc_q;
    logic [W-1:0]     acc_q;
    logic [W-1:0]     out_data_q;
    logic             out_valid_q;
    logic [W-1:0]     first_psum;

    logic             start_ok;
    logic             accept;
    logic             last_group;

    assign start_ok = (state_q == ST_IDLE) && i_start && (i_num_groups != '0);
    assign accept   = (state_q == ST_RUN) && i_in_valid;

`ifdef NFU2_SEQ_INIT_PSUM_EN
    logic [W-1:0] init_q;

    // Initial partial value, captured when a window is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_q <= '0;
        end else if (start_ok) begin
            init_q <= i_init_psum;
        end
    end

    assign first_psum = init_q;
`else
    assign first_psum = '0;
`endif

    nfu2_group_counter #(
        .CNT_W (CNT_W)
    ) u_group_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .inc        (accept),
        .num_groups (num_q),
        .last       (last_group)
    );

    // Controller FSM plus the accumulator / result registers it owns.
    // i_tree_res lags the accepted group by one cycle, so pipe_v_q marks the
    // cycles in which the cluster output is real and may be accumulated.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_SUM;
            num_q       <= '0;
            pipe_v_q    <= 1'b0;
            use_acc_q   <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pipe_v_q <= accept;
            if (pipe_v_q) begin
                acc_q     <= i_tree_res;
                use_acc_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        op_q      <= i_op;
                        num_q     <= i_num_groups;
                        use_acc_q <= 1'b0;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && last_group) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    out_data_q  <= i_tree_res;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_out_ready) begin
                        out_valid_q <= 1'b0;
                        use_acc_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_in_ready  = (state_q == ST_RUN);
    assign o_tree_op   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) ? op_q : OP_SUM;
    assign o_tree_psum = use_acc_q ? acc_q : first_psum;
    assign o_out_valid = out_valid_q;
    assign o_out_data  = out_data_q;

endmodule

// File: tb/tb_nfu2_window_seq.sv
// Directed bench for nfu2_window_seq with a behavioural two-stage cluster:
// stage 1 registers the reduced input group, stage 2 combines it with the
// psum operand (add or unsigned max, per lane, modulo 2^N).
module tb_nfu2_window_seq;
    import nfu2_pkg::*;

    localparam int N  = 16;
    localparam int TN = 16;
    localparam int CW = 8;
    localparam int W  = TN * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          i_op;
    logic [CW-1:0] i_num_groups;
    logic          o_busy;
    logic          i_in_valid;
    logic          o_in_ready;
    logic          o_tree_op;
    logic [W-1:0]  o_tree_psum;
    logic [W-1:0]  tree_res;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [W-1:0]  o_out_data;
`ifdef NFU2_SEQ_INIT_PSUM_EN
    logic [W-1:0]  i_init_psum;
`endif

    logic [W-1:0]  tree_in;
    logic [W-1:0]  stage1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nfu2_window_seq #(
        .N     (N),
        .Tn    (TN),
        .CNT_W (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_op         (i_op),
        .i_num_groups (i_num_groups),
`ifdef NFU2_SEQ_INIT_PSUM_EN
        .i_init_psum  (i_init_psum),
`endif
        .o_busy       (o_busy),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .o_tree_op    (o_tree_op),
        .o_tree_psum  (o_tree_psum),
        .i_tree_res   (tree_res),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data)
    );

    // Cluster stage 1: reduced input group registered every cycle.
    always @(posedge clk) stage1 <= tree_in;

    // Cluster stage 2: combine stage 1 with the psum operand per lane.
    always_comb begin
        tree_res = '0;
        for (int l = 0; l < TN; l++) begin
            if (o_tree_op)
                tree_res[l*N +: N] = (stage1[l*N +: N] > o_tree_psum[l*N +: N]) ?
                                     stage1[l*N +: N] : o_tree_psum[l*N +: N];
            else
                tree_res[l*N +: N] = stage1[l*N +: N] + o_tree_psum[l*N +: N];
        end
    end

    function automatic logic [W-1:0] fill(input logic [N-1:0] v);
        return {TN{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        i_start      = 1'b0;
        i_op         = 1'b0;
        i_num_groups = '0;
        i_in_valid   = 1'b0;
        i_out_ready  = 1'b1;
        tree_in      = '0;
`ifdef NFU2_SEQ_INIT_PSUM_EN
        i_init_psum  = '0;
`endif

        // Reset
        tick();
        tick();
        chk("rst_busy", W'(o_busy), W'(0));
        chk("rst_in_ready", W'(o_in_ready), W'(0));
        chk("rst_tree_op", W'(o_tree_op), W'(0));
        chk("rst_psum", o_tree_psum, '0);
        rst = 1'b0;
        tick();
        chk("post_rst_busy", W'(o_busy), W'(0));
        chk("post_rst_in_ready", W'(o_in_ready), W'(0));
        chk("post_rst_psum", o_tree_psum, '0);
        chk("post_rst_out_valid", W'(o_out_valid), W'(0));
        chk("post_rst_out_data", o_out_data, '0);

        // Sum, 3 groups back-to-back, 16 per lane per group -> 48
        i_start = 1'b1; i_op = OP_SUM; i_num_groups = 8'd3;
        tick();
        i_start = 1'b0;
        chk("sum_busy", W'(o_busy), W'(1));
        chk("sum_in_ready", W'(o_in_ready), W'(1));
        chk("sum_psum_first", o_tree_psum, '0);
        i_in_valid = 1'b1; tree_in = fill(16'd16);
        tick();
        chk("sum_psum_g1_pipe", o_tree_psum, '0);
        tick();
        chk("sum_psum_g3", o_tree_psum, fill(16'd16));
        tick();
        i_in_valid = 1'b0; tree_in = fill(16'hBEEF);
        chk("sum_drain_in_ready", W'(o_in_ready), W'(0));
        chk("sum_drain_out_valid", W'(o_out_valid), W'(0));
        chk("sum_drain_psum", o_tree_psum, fill(16'd32));
        tick();
        chk("sum_out_valid", W'(o_out_valid), W'(1));
        chk("sum_out_data", o_out_data, fill(16'd48));
        tick();
        chk("sum_idle_busy", W'(o_busy), W'(0));
        chk("sum_idle_out_valid", W'(o_out_valid), W'(0));

        // Max, 2 groups, lanes 5 then 9 -> 9; op held through DRAIN
        i_start = 1'b1; i_op = OP_MAX; i_num_groups = 8'd2;
        tick();
        i_start = 1'b0;
        chk("max_op_run", W'(o_tree_op), W'(1));
        i_in_valid = 1'b1; tree_in = fill(16'd5);
        tick();
        tree_in = fill(16'd9);
        chk("max_psum_first", o_tree_psum, '0);
        tick();
        i_in_valid = 1'b0; tree_in = '0;
        chk("max_op_drain", W'(o_tree_op), W'(1));
        chk("max_psum_drain", o_tree_psum, fill(16'd5));
        tick();
        chk("max_out_data", o_out_data, fill(16'd9));
        chk("max_op_out", W'(o_tree_op), W'(0));
        tick();

        // Sum, 4 groups (1,2,3,4) with a 2-cycle bubble after group 2 -> 10
        i_start = 1'b1; i_op = OP_SUM; i_num_groups = 8'd4;
        tick();
        i_start = 1'b0;
        i_in_valid = 1'b1; tree_in = fill(16'd1);
        tick();
        tree_in = fill(16'd2);
        chk("bub_psum_first", o_tree_psum, '0);
        tick();
        i_in_valid = 1'b0; tree_in = fill(16'h1111);
        chk("bub_psum_g2", o_tree_psum, fill(16'd1));
        tick();
        chk("bub_acc_static1", o_tree_psum, fill(16'd3));
        tick();
        chk("bub_acc_static2", o_tree_psum, fill(16'd3));
        i_in_valid = 1'b1; tree_in = fill(16'd3);
        tick();
        tree_in = fill(16'd4);
        chk("bub_psum_g4", o_tree_psum, fill(16'd3));
        tick();
        i_in_valid = 1'b0; tree_in = '0;
        chk("bub_psum_drain", o_tree_psum, fill(16'd6));
        tick();
        chk("bub_out_data", o_out_data, fill(16'd10));
        tick();

        // Back-pressure in OUT: data stable, start ignored
        i_out_ready = 1'b0;
        i_start = 1'b1; i_op = OP_SUM; i_num_groups = 8'd1;
        tick();
        i_start = 1'b0;
        i_in_valid = 1'b1; tree_in = fill(16'd7);
        tick();
        i_in_valid = 1'b0; tree_in = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", W'(o_out_valid), W'(1));
            chk("bp_out_data", o_out_data, fill(16'd7));
            chk("bp_in_ready", W'(o_in_ready), W'(0));
            i_start = (k == 1); i_num_groups = 8'd2;
            tick();
        end
        i_start = 1'b0;
        chk("bp_still_out", W'(o_out_valid), W'(1));
        i_out_ready = 1'b1;
        tick();
        chk("bp_idle_busy", W'(o_busy), W'(0));
        chk("bp_idle_out_valid", W'(o_out_valid), W'(0));

        // Zero-group start ignored
        i_start = 1'b1; i_num_groups = 8'd0;
        tick();
        i_start = 1'b0;
        chk("zero_busy", W'(o_busy), W'(0));
        chk("zero_in_ready", W'(o_in_ready), W'(0));

        // Reset mid-window after one group
        i_start = 1'b1; i_op = OP_MAX; i_num_groups = 8'd3;
        tick();
        i_start = 1'b0;
        i_in_valid = 1'b1; tree_in = fill(16'd5);
        tick();
        i_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", W'(o_busy), W'(0));
        chk("mid_rst_in_ready", W'(o_in_ready), W'(0));
        chk("mid_rst_tree_op", W'(o_tree_op), W'(0));
        chk("mid_rst_psum", o_tree_psum, '0);
        chk("mid_rst_out_valid", W'(o_out_valid), W'(0));
        chk("mid_rst_out_data", o_out_data, '0);
        rst = 1'b0;

        // Fresh window after reset: sum 2 groups of 3 -> 6
        i_start = 1'b1; i_op = OP_SUM; i_num_groups = 8'd2;
        tick();
        i_start = 1'b0;
        i_in_valid = 1'b1; tree_in = fill(16'd3);
        tick();
        tick();
        i_in_valid = 1'b0; tree_in = '0;
        tick();
        chk("after_rst_out_valid", W'(o_out_valid), W'(1));
        chk("after_rst_out_data", o_out_data, fill(16'd6));
        tick();

`ifdef NFU2_SEQ_INIT_PSUM_EN
        // Initial psum 100 plus one group of 16 -> 116
        i_init_psum = fill(16'd100);
        i_start = 1'b1; i_op = OP_SUM; i_num_groups = 8'd1;
        tick();
        i_start = 1'b0; i_init_psum = '0;
        i_in_valid = 1'b1; tree_in = fill(16'd16);
        tick();
        i_in_valid = 1'b0; tree_in = '0;
        chk("init_psum_drain", o_tree_psum, fill(16'd100));
        tick();
        chk("init_out_data", o_out_data, fill(16'd116));
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
